pass_entry: RTL and testbench

PASS_ENTRY -- requirements
Module: pass_entry

---
 rtl/pass_entry.sv | 152 +++++++++++++++
 tb/tb_pass_entry.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pass_entry.sv
// pass_entry: collects four 4-bit digits from slide switches into a 16-bit word.
// The word is then offered downstream with a valid/ready handshake.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   i_sw          raw switch nibble (asynchronous)
//   i_btn_enter   raw pushbutton, commits i_sw as the next digit
//   i_btn_clear   raw pushbutton, discards a partial entry
//   i_out_ready   downstream ready to accept o_word
//   o_word        assembled entry, first digit in [15:12]
//   o_data_valid  o_word complete and offered downstream
//   o_digit_cnt   digits entered so far, 0..4
//
// state     | meaning
// S_COLLECT | accepting digits; clear and idle timeout discard a partial entry
// S_OFFER   | word complete, held until the downstream handshake
module pass_entry #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_sw,
  input  logic        i_btn_enter,
  input  logic        i_btn_clear,
  input  logic        i_out_ready,
  output logic [15:0] o_word,
  output logic        o_data_valid,
  output logic [2:0]  o_digit_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_COLLECT, S_OFFER} state_t;

  // Button index 0 = enter, 1 = clear.
  logic [1:0]      w_btn_raw;
  logic [3:0]      r_sw_s1, r_sw_s2;
  logic [1:0]      r_btn_s1, r_btn_s2;
  logic [1:0]      r_age;
  logic [1:0]      r_db, r_db_q, r_arm, r_pulse;
  logic [DB_W-1:0] r_db_cnt [2];

  state_t          r_state, w_state_nx;
  logic [15:0]     r_word, w_word_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic [TO_W-1:0] r_to_cnt, w_to_nx;
  logic            w_ent, w_clr;

  assign w_btn_raw = {i_btn_clear, i_btn_enter};

  // Synchronizers, debouncers and press-pulse generation.
  // r_age marks when the synchronizer holds a genuine post-reset sample; a
  // button only becomes armed once it has been seen released after reset,
  // so a button held through reset cannot produce a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_age    <= '0;
      r_db     <= '0;
      r_db_q   <= '0;
      r_arm    <= '0;
      r_pulse  <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sw_s1  <= i_sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_age    <= {r_age[0], 1'b1};
      r_db_q   <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_btn_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
        if (r_age[1] && !r_btn_s2[i]) r_arm[i] <= 1'b1;
        r_pulse[i] <= r_db[i] & ~r_db_q[i] & r_arm[i];
      end
    end
  end

  assign w_ent = r_pulse[0];
  assign w_clr = r_pulse[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_COLLECT;
      r_word   <= '0;
      r_cnt    <= '0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_word   <= w_word_nx;
      r_cnt    <= w_cnt_nx;
      r_to_cnt <= w_to_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_word_nx  = r_word;
    w_cnt_nx   = r_cnt;
    w_to_nx    = '0;
    case (r_state)
      S_COLLECT: begin
        if (w_clr) begin
          w_word_nx = '0;
          w_cnt_nx  = '0;
        end else if (w_ent) begin
          if (r_cnt < 3'd4) begin
            w_word_nx = {r_word[11:0], r_sw_s2};
            w_cnt_nx  = r_cnt + 3'd1;
            if (r_cnt == 3'd3) w_state_nx = S_OFFER;
          end
        end else if (r_cnt != 3'd0) begin
          // In COLLECT a nonzero count is always 1..3, so the idle timer runs.
          if (r_to_cnt == TO_LAST) begin
            w_word_nx = '0;
            w_cnt_nx  = '0;
          end else begin
            w_to_nx = r_to_cnt + TO_W'(1);
          end
        end
      end
      S_OFFER: begin
        if (i_out_ready) begin
          w_state_nx = S_COLLECT;
          w_word_nx  = '0;
          w_cnt_nx   = '0;
        end
      end
      default: w_state_nx = S_COLLECT;
    endcase
  end

  assign o_word       = r_word;
  assign o_digit_cnt  = r_cnt;
  assign o_data_valid = (r_state == S_OFFER);

endmodule

// File: tb/tb_pass_entry.sv
// tb_pass_entry: directed bench for pass_entry with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=50. A small model tracks the expected word/count; expected
// states are queued as stimulus is driven and popped when checked.
module tb_pass_entry;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  i_sw = 4'h0;
  logic        i_btn_enter = 1'b0;
  logic        i_btn_clear = 1'b0;
  logic        i_out_ready = 1'b0;
  logic [15:0] o_word;
  logic        o_data_valid;
  logic [2:0]  o_digit_cnt;

  pass_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_sw         (i_sw),
    .i_btn_enter  (i_btn_enter),
    .i_btn_clear  (i_btn_clear),
    .i_out_ready  (i_out_ready),
    .o_word       (o_word),
    .o_data_valid (o_data_valid),
    .o_digit_cnt  (o_digit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [2:0]  cnt;
    logic        valid;
  } exp_t;

  exp_t        q_exp[$];
  logic [15:0] q_out[$];
  logic [15:0] m_word = 16'h0;
  logic [2:0]  m_cnt = 3'd0;
  int          n_total = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.word  = m_word;
    e.cnt   = m_cnt;
    e.valid = (m_cnt == 3'd4);
    q_exp.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (q_exp.size() == 0) begin
      n_total++;
      n_bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = q_exp.pop_front();
      chk({tag, "_word"},  32'(o_word),       32'(e.word));
      chk({tag, "_cnt"},   32'(o_digit_cnt),  32'(e.cnt));
      chk({tag, "_valid"}, 32'(o_data_valid), 32'(e.valid));
    end
  endtask

  task automatic model_enter(input logic [3:0] d);
    if (m_cnt < 3'd4) begin
      m_word = {m_word[11:0], d};
      m_cnt  = m_cnt + 3'd1;
      if (m_cnt == 3'd4) q_out.push_back(m_word);
    end
    push_model();
  endtask

  task automatic model_clear();
    if (m_cnt < 3'd4) begin
      m_word = 16'h0;
      m_cnt  = 3'd0;
    end
    push_model();
  endtask

  task automatic btn_press(input logic ent, input logic clr, input int hold);
    @(negedge clk);
    i_btn_enter = ent;
    i_btn_clear = clr;
    repeat (hold) @(negedge clk);
    i_btn_enter = 1'b0;
    i_btn_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic enter_digit(input logic [3:0] d, input string tag);
    i_sw = d;
    model_enter(d);
    btn_press(1'b1, 1'b0, 12);
    check_sb(tag);
  endtask

  task automatic clear_press(input string tag);
    model_clear();
    btn_press(1'b0, 1'b1, 12);
    check_sb(tag);
  endtask

  task automatic transfer(input string tag);
    logic [15:0] exp_w;
    @(negedge clk);
    chk({tag, "_pre_valid"}, 32'(o_data_valid), 32'd1);
    if (q_out.size() == 0) begin
      n_total++;
      n_bad++;
      $error("FAIL %s no offered word queued", tag);
    end else begin
      exp_w = q_out.pop_front();
      chk({tag, "_offer_word"}, 32'(o_word), 32'(exp_w));
    end
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    m_word = 16'h0;
    m_cnt  = 3'd0;
    push_model();
    check_sb({tag, "_post"});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_word",  32'(o_word),       32'h0);
    chk("rst_valid", 32'(o_data_valid), 32'h0);
    chk("rst_cnt",   32'(o_digit_cnt),  32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Four clean digits, downstream not ready.
    enter_digit(4'hA, "a550_d1");
    enter_digit(4'h5, "a550_d2");
    enter_digit(4'h5, "a550_d3");
    enter_digit(4'h0, "a550_d4");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("offer_hold_valid", 32'(o_data_valid), 32'd1);
      chk("offer_hold_word",  32'(o_word),       32'hA550);
    end

    // Presses during OFFER are ignored.
    enter_digit(4'h3, "offer_ign_enter1");
    clear_press("offer_ign_clear");
    enter_digit(4'h7, "offer_ign_enter2");
    transfer("xfer_a550");

    // Bouncing enter with out_ready held high in COLLECT: exactly one digit.
    i_sw = 4'h9;
    i_out_ready = 1'b1;
    model_enter(4'h9);
    for (int k = 0; k < 15; k++) begin
      i_btn_enter = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    i_btn_enter = 1'b1;
    repeat (12) @(negedge clk);
    i_btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    i_out_ready = 1'b0;
    check_sb("bounce_one_digit");
    clear_press("bounce_clear");

    // Idle timeout on a partial entry.
    enter_digit(4'h3, "to_d1");
    enter_digit(4'hC, "to_d2");
    repeat (25) @(negedge clk);
    chk("to_not_yet_cnt",  32'(o_digit_cnt), 32'd2);
    chk("to_not_yet_word", 32'(o_word),      32'h003C);
    repeat (15) @(negedge clk);
    m_word = 16'h0;
    m_cnt  = 3'd0;
    push_model();
    check_sb("to_expired");
    enter_digit(4'h7, "to_next_digit");
    clear_press("to_clear");

    // Simultaneous enter and clear: clear wins.
    enter_digit(4'h1, "sim_d1");
    enter_digit(4'h2, "sim_d2");
    enter_digit(4'h3, "sim_d3");
    i_sw = 4'hE;
    model_clear();
    btn_press(1'b1, 1'b1, 12);
    check_sb("sim_clear_wins");

    // Reset while offering, enter held through reset.
    enter_digit(4'hF, "rst_d1");
    enter_digit(4'h0, "rst_d2");
    enter_digit(4'h0, "rst_d3");
    enter_digit(4'hD, "rst_d4");
    repeat (60) @(negedge clk);
    chk("offer_no_timeout_valid", 32'(o_data_valid), 32'd1);
    chk("offer_no_timeout_word",  32'(o_word),       32'hF00D);
    i_btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_offer_valid", 32'(o_data_valid), 32'd0);
    chk("rst_offer_cnt",   32'(o_digit_cnt),  32'd0);
    chk("rst_offer_word",  32'(o_word),       32'h0);
    reset = 1'b0;
    m_word = 16'h0;
    m_cnt  = 3'd0;
    q_out.delete();
    repeat (20) @(negedge clk);
    chk("held_no_capture_cnt",  32'(o_digit_cnt), 32'd0);
    chk("held_no_capture_word", 32'(o_word),      32'h0);
    i_btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("released_no_capture_cnt", 32'(o_digit_cnt), 32'd0);
    enter_digit(4'h6, "repress_after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
